checksum_verify_array: RTL and testbench
========================================

Name: checksum_verify_array

Overview:
- Parametrised successor of the single-column checksum verifier for the fault-tolerant matrix-multiply accelerator.
- Consumes the full-encoded result matrix Cf, one row per handshake: N data rows, then 1 column-checksum row, each row N+1 elements wide.
- Performs both row-checksum and column-checksum verification and localises a single faulty element (row index, column index).
- Outputs the arithmetic delta needed by the correction stage; sits between the MAC array write-back and the correction controller.

Parameters:
- N, 32, data dimension; Cf is (N+1)x(N+1).
- DW, 32, element width; all sums are modulo 2^DW.
- IW, $clog2(N+1), index width for err_row/err_col.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; clears accumulators, begins a new matrix
- row_valid  in  1  row_data valid
- row_ready  out  1  block accepts a row
- row_data  in  (N+1)*DW  row of Cf; element k at [DW*k +: DW]
- row_indicator  out  N+1  bit r=1: row r fails row check
- column_indicator  out  N+1  bit c=1: column c fails column check
- error  out  1  OR of both indicators
- single_error  out  1  exactly one row bit and one column bit set
- err_row  out  IW  failing row index (valid when single_error)
- err_col  out  IW  failing column index (valid when single_error)
- err_delta  out  DW  column_sum[err_col] - checksum[err_col], mod 2^DW
- done  out  1  results valid; level, held until start or rst
- err_count  out  16  matrices with error (see Optional Feature)

Behaviour:
- rst: state IDLE; all accumulators, indicators, err_row/err_col/err_delta, error, single_error, done, err_count reset to 0. rst overrides start and all other inputs, including mid-operation.
- States: IDLE, ACCUM, COMPARE, DONE.
  - IDLE --start--> ACCUM.
  - ACCUM --(N+1)th row accepted--> COMPARE.
  - COMPARE --1 cycle--> DONE.
  - DONE --start--> ACCUM.
- start in any state: clears column accumulators, row counter, indicators and done; next state ACCUM.
- row_ready = (state==ACCUM) && !start. Accept = row_valid && row_ready. Gaps (row_valid low) are allowed; no timeout.
- Per accepted data row r (counter 0..N-1):
  - row_indicator[r] <= (sum of elements 0..N-1) != element N.
  - col_acc[k] += element k, for k = 0..N.
- Checksum row (counter==N):
  - row_indicator[N] computed the same way.
  - Row latched into the chk register; no accumulation.
- COMPARE: column_indicator[k] <= col_acc[k] != chk[k] for k = 0..N. Derive error, single_error, err_row/err_col and err_delta.
- done rises exactly 1 cycle after the checksum row is accepted; all outputs are stable while done=1.
- Localisation:
  - err_row/err_col = index of the lowest set bit of row_indicator/column_indicator.
  - single_error = popcount(row)==1 && popcount(col)==1.
  - When !single_error: err_row, err_col and err_delta are 0.
- Arithmetic: all additions truncate to DW bits (wrap-around); no saturation flags.
- Row data presented while in IDLE/COMPARE/DONE is ignored (row_ready=0).
- Indicators from the previous matrix persist through DONE; they are cleared only by start or rst.

Optional Feature:
- Macro CHKV_ERR_COUNT_EN.
- Defined: err_count increments by 1 on each COMPARE with error=1, and saturates at 16'hFFFF. It is cleared only by rst, not by start.
- Undefined: err_count tied to 0; no counter flops are synthesised; the port stays present.

Decomposition:
- Package chkv_pkg:
  - state enum (IDLE, ACCUM, COMPARE, DONE)
  - popcount and lowest-set-bit index functions
  - IW derivation helper
- Sub-module chkv_row_adder: combinational N-input DW-bit adder tree (mod 2^DW). Instantiated once for the row-sum check; N+1 parallel accumulators stay in the top level.

Test Plan (bench params N=4, DW=8):
- Clean matrix: data all 8'h01, element 4 = 8'h04; checksum row {04,04,04,04,10}. Expected: done 1 cycle after 5th accept; error=0; both indicators 5'b0.
- Single fault: data row 2, col 1 set to 8'h04 (+3), checksums unchanged. Expected: row_indicator=5'b00100, column_indicator=5'b00010, single_error=1, err_row=2, err_col=1, err_delta=8'h03.
- Wrap-around: all data 8'hFF; row checksum 8'hFC; checksum row {FC,FC,FC,FC,F0}. Expected: error=0 (mod-256 sums).
- Double fault: (0,0)+1 and (3,2)+1. Expected: error=1, single_error=0, err_row=err_col=err_delta=0, row_indicator=5'b01001, column_indicator=5'b00101.
- Restart and backpressure: accept 2 rows, pulse start concurrently with row_valid (row not accepted), then a clean matrix with random valid gaps. Expected: clean result; row_ready=0 throughout DONE.
- rst mid-ACCUM after 3 rows: all outputs 0, state IDLE, row_ready=0. With CHKV_ERR_COUNT_EN, 3 faulty matrices then 1 clean give err_count=3.

Source files
------------

// File: rtl/chkv_pkg.sv
// chkv_pkg: shared types and helpers for the checksum verifier array
package chkv_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
  localparam int MAXW = 1024;
  function automatic int chkv_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int popcount(input logic [MAXW-1:0] v);
    int c = 0;
    for (int i = 0; i < MAXW; i++) c += int'(v[i]);
    return c;
  endfunction
  function automatic int lsb_idx(input logic [MAXW-1:0] v);
    int idx = 0;
    for (int i = MAXW - 1; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/chkv_row_adder.sv
// chkv_row_adder: combinational N-input DW-bit adder tree, sum mod 2^DW
module chkv_row_adder #(
  parameter int N  = 32,
  parameter int DW = 32
) (
  input  logic [N*DW-1:0] terms,
  output logic [DW-1:0]   sum
);
  localparam int P = 1 << $clog2(N);
  logic [P*DW-1:0] ext;
  logic [DW-1:0]   t [P];
  assign ext = (P*DW)'(terms);
  always_comb begin
    for (int i = 0; i < P; i++) t[i] = ext[i*DW +: DW];
    for (int s = P / 2; s > 0; s = s / 2)
      for (int i = 0; i < s; i++) t[i] = t[2*i] + t[2*i+1];
  end
  assign sum = t[0];
endmodule

// File: rtl/checksum_verify_array.sv
// checksum_verify_array: row+column checksum check of (N+1)x(N+1) Cf with single-fault localisation; CHKV_ERR_COUNT_EN enables err_count
module checksum_verify_array import chkv_pkg::*; #(
  parameter int N  = 32,
  parameter int DW = 32,
  parameter int IW = chkv_idx_w(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                row_valid,
  output logic                row_ready,
  input  logic [(N+1)*DW-1:0] row_data,
  output logic [N:0]          row_indicator,
  output logic [N:0]          column_indicator,
  output logic                error,
  output logic                single_error,
  output logic [IW-1:0]       err_row,
  output logic [IW-1:0]       err_col,
  output logic [DW-1:0]       err_delta,
  output logic                done,
  output logic [15:0]         err_count
);
  state_t        state, state_n;
  logic [IW-1:0] row_cnt;
  logic [DW-1:0] col_acc [N+1];
  logic [DW-1:0] chk     [N+1];
  logic [DW-1:0] row_sum;
  logic [N:0]    col_cmp;
  logic          accept, last_row, any_err, one_err;
  logic [IW-1:0] e_row, e_col;

  chkv_row_adder #(.N(N), .DW(DW)) u_adder (
    .terms(row_data[N*DW-1:0]),
    .sum  (row_sum)
  );

  assign accept   = row_valid && row_ready;
  assign last_row = row_cnt == IW'(N);

  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  always_comb begin
    state_n = start                 ? ACCUM   :
              (accept && last_row)  ? COMPARE :
              (state == COMPARE)    ? DONE    : state;
  end

  always_comb row_ready = (state == ACCUM) && !start;

  always_comb begin
    for (int k = 0; k <= N; k++) col_cmp[k] = col_acc[k] != chk[k];
    any_err = |row_indicator || |col_cmp;
    one_err = popcount(MAXW'(row_indicator)) == 1 && popcount(MAXW'(col_cmp)) == 1;
    e_row   = IW'(lsb_idx(MAXW'(row_indicator)));
    e_col   = IW'(lsb_idx(MAXW'(col_cmp)));
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      row_cnt          <= '0;
      row_indicator    <= '0;
      column_indicator <= '0;
      error            <= 1'b0;
      single_error     <= 1'b0;
      err_row          <= '0;
      err_col          <= '0;
      err_delta        <= '0;
      done             <= 1'b0;
      for (int k = 0; k <= N; k++) col_acc[k] <= '0;
      if (rst) for (int k = 0; k <= N; k++) chk[k] <= '0;
    end else begin
      if (accept) begin
        row_indicator[row_cnt] <= row_sum != row_data[N*DW +: DW];
        row_cnt                <= row_cnt + 1'b1;
        // the final row carries the column checksums and is only latched
        for (int k = 0; k <= N; k++)
          if (last_row) chk[k] <= row_data[k*DW +: DW];
          else col_acc[k] <= col_acc[k] + row_data[k*DW +: DW];
      end
      if (state == COMPARE) begin
        column_indicator <= col_cmp;
        error            <= any_err;
        single_error     <= one_err;
        err_row          <= one_err ? e_row : '0;
        err_col          <= one_err ? e_col : '0;
        err_delta        <= one_err ? col_acc[e_col] - chk[e_col] : '0;
        done             <= 1'b1;
      end
    end
  end

`ifdef CHKV_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (state == COMPARE && !start && any_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_checksum_verify_array.sv
// tb_checksum_verify_array: scoreboard bench for checksum_verify_array at N=4, DW=8
module tb_checksum_verify_array;
  import chkv_pkg::*;
  localparam int N = 4, DW = 8, IW = 3;

  typedef struct {
    logic [4:0] ri, ci;
    logic       e, s;
    logic [2:0] r, c;
    logic [7:0] d;
  } exp_t;

  logic          clk = 0, rst = 1, start = 0, row_valid = 0;
  logic [39:0]   row_data = '0;
  logic          row_ready, error, single_error, done;
  logic [4:0]    row_indicator, column_indicator;
  logic [IW-1:0] err_row, err_col;
  logic [7:0]    err_delta;
  logic [15:0]   err_count;

  exp_t        sb[$];
  exp_t        cur;
  logic [39:0] m [5];
  int          n_chk = 0, n_fail = 0, cyc = 0, last_acc = -10, n_pushed = 0, n_done = 0;
  logic        done_q = 0;

  checksum_verify_array #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_indicator(row_indicator), .column_indicator(column_indicator),
    .error(error), .single_error(single_error), .err_row(err_row), .err_col(err_col),
    .err_delta(err_delta), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] ri, ci, input logic e, s,
                              input logic [2:0] r, c, input logic [7:0] d);
    exp_t x;
    x.ri = ri; x.ci = ci; x.e = e; x.s = s; x.r = r; x.c = c; x.d = d;
    return x;
  endfunction

  always @(negedge clk) begin
    if (row_valid && row_ready) last_acc = cyc;
    if (done && !done_q) begin
      n_done++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        cur = sb.pop_front();
        check("done_latency", 64'(cyc - last_acc), 2);
        check("row_indicator", row_indicator, cur.ri);
        check("column_indicator", column_indicator, cur.ci);
        check("error", error, cur.e);
        check("single_error", single_error, cur.s);
        check("err_row", err_row, cur.r);
        check("err_col", err_col, cur.c);
        check("err_delta", err_delta, cur.d);
      end
    end
    if (done) check("ready_in_done", row_ready, 0);
    done_q = done;
  end

  task automatic send_row(input logic [39:0] r, input int gap);
    bit ok = 0;
    row_data = r;
    row_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (row_ready) begin ok = 1; break; end
    end
    if (!ok) check("row_ready_timeout", 0, 1);
    @(posedge clk); #1;
    row_valid = 0;
    repeat (gap > 0 ? $urandom_range(0, gap) : 0) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        row_valid = 1;
        row_data = '1;
        repeat (3) @(posedge clk);
        #1 row_valid = 0;
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic feed(input int gap);
    for (int r = 0; r < 5; r++) send_row(m[r], gap);
    wait_done();
  endtask

  task automatic run_matrix(input exp_t e, input int gap);
    pulse_start();
    sb.push_back(e);
    n_pushed++;
    feed(gap);
  endtask

  task automatic set_clean();
    for (int r = 0; r < 4; r++) m[r] = 40'h04_01_01_01_01;
    m[4] = 40'h10_04_04_04_04;
  endtask

  task automatic set_single();
    set_clean();
    m[2] = 40'h04_01_01_04_01;
  endtask

  task automatic set_double();
    set_clean();
    m[0] = 40'h04_01_01_01_02;
    m[3] = 40'h04_01_02_01_01;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_row_ready", row_ready, 0);
    check("rst_error", error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dut.state, IDLE);

    set_clean();
    run_matrix(mk(5'b0, 5'b0, 0, 0, 0, 0, 8'h00), 0);
    set_single();
    run_matrix(mk(5'b00100, 5'b00010, 1, 1, 3'd2, 3'd1, 8'h03), 0);
    for (int r = 0; r < 4; r++) m[r] = 40'hFC_FF_FF_FF_FF;
    m[4] = 40'hF0_FC_FC_FC_FC;
    run_matrix(mk(5'b0, 5'b0, 0, 0, 0, 0, 8'h00), 0);
    set_double();
    run_matrix(mk(5'b01001, 5'b00101, 1, 0, 0, 0, 8'h00), 1);

    // abort a faulty matrix with start while a row is offered, then a clean one with gaps
    pulse_start();
    send_row(m[0], 0);
    send_row(m[1], 0);
    row_data = m[2];
    row_valid = 1;
    start = 1;
    @(negedge clk);
    check("ready_during_start", row_ready, 0);
    @(posedge clk); #1;
    start = 0;
    row_valid = 0;
    set_clean();
    sb.push_back(mk(5'b0, 5'b0, 0, 0, 0, 0, 8'h00));
    n_pushed++;
    feed(3);

    // reset in the middle of a faulty matrix
    set_single();
    pulse_start();
    for (int r = 0; r < 3; r++) send_row(m[r], 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("mid_rst_state", dut.state, IDLE);
    check("mid_rst_row_ready", row_ready, 0);
    check("mid_rst_row_ind", row_indicator, 0);
    check("mid_rst_col_ind", column_indicator, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_single", single_error, 0);
    check("mid_rst_err_row", err_row, 0);
    check("mid_rst_err_col", err_col, 0);
    check("mid_rst_err_delta", err_delta, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err_count", err_count, 0);

    set_single();
    for (int k = 0; k < 3; k++) run_matrix(mk(5'b00100, 5'b00010, 1, 1, 3'd2, 3'd1, 8'h03), 0);
    set_clean();
    run_matrix(mk(5'b0, 5'b0, 0, 0, 0, 0, 8'h00), 0);
    @(negedge clk);
`ifdef CHKV_ERR_COUNT_EN
    check("err_count", err_count, 3);
`else
    check("err_count", err_count, 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
